// File: rtl/cpu_pkg.sv
// Definitions shared by the control unit and the ALU: opcodes, sequencer
// states and the bit positions of the instruction fields.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_MEM,
        ST_HALT
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/reg_file.sv
// General register file: two asynchronous read ports, one synchronous
// write port, all registers cleared by reset.
module reg_file
    import cpu_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] i_raddr_a,
    output logic [DATA_W-1:0]        o_rdata_a,
    input  logic [$clog2(NREGS)-1:0] i_raddr_b,
    output logic [DATA_W-1:0]        o_rdata_b,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch-decode-execute sequencer: walks each instruction through the shared
// memory port and the external ALU, one instruction at a time.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [3:0]        alu_opcode,
    output logic [15:0]       alu_num1,
    output logic [15:0]       alu_num2,
    input  logic [15:0]       alu_result,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_started;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [15:0]       r_a;
    logic [15:0]       r_b;
    logic [15:0]       r_res;
    logic [15:0]       r_alu_num1;
    logic [15:0]       r_alu_num2;

    logic [3:0]        w_op;
    logic [3:0]        w_rd;
    logic [3:0]        w_rs1;
    logic [3:0]        w_rs2;
    logic [7:0]        w_imm;
    logic              w_is_alu;
    logic              w_mem_done;
    logic              w_rf_we;
    logic [3:0]        w_rf_raddr_b;
    logic [15:0]       w_rf_wdata;
    logic [15:0]       w_rf_rdata_a;
    logic [15:0]       w_rf_rdata_b;

    assign w_op       = r_ir[OP_MSB:OP_LSB];
    assign w_rd       = r_ir[RD_MSB:RD_LSB];
    assign w_rs1      = r_ir[RS1_MSB:RS1_LSB];
    assign w_rs2      = r_ir[RS2_MSB:RS2_LSB];
    assign w_imm      = r_ir[IMM_MSB:IMM_LSB];
    assign w_is_alu   = is_alu_op(w_op);
    assign w_mem_done = mem_req && mem_ready;
    assign pc_out     = r_pc;

    // STORE reads its data register through port B in place of rs2.
    assign w_rf_raddr_b = (w_op == OP_STORE) ? w_rd : w_rs2;
    assign w_rf_we      = (r_state == ST_WRITEBACK) ||
                          ((r_state == ST_MEM) && w_mem_done && (w_op == OP_LOAD));
    assign w_rf_wdata   = (r_state == ST_WRITEBACK) ? r_res : mem_rdata;

    reg_file #(
        .NREGS  (NREGS),
        .DATA_W (16)
    ) u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .i_raddr_a (w_rs1),
        .o_rdata_a (w_rf_rdata_a),
        .i_raddr_b (w_rf_raddr_b),
        .o_rdata_b (w_rf_rdata_b),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_rf_wdata)
    );

    // r_started keeps the bus idle for the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_started <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_FETCH:     if (w_mem_done) w_next_state = ST_DECODE;
            ST_DECODE:    w_next_state = ST_EXECUTE;
            ST_EXECUTE: begin
                if (w_is_alu || (w_op == OP_LDI)) begin
                    w_next_state = ST_WRITEBACK;
                end else if ((w_op == OP_LOAD) || (w_op == OP_STORE)) begin
                    w_next_state = ST_MEM;
                end else if (w_op == OP_HALT) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_WRITEBACK: w_next_state = ST_FETCH;
            ST_MEM:       if (w_mem_done) w_next_state = ST_FETCH;
            ST_HALT:      w_next_state = ST_HALT;
            default:      w_next_state = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        alu_opcode = OP_NOP;
        alu_num1   = r_alu_num1;
        alu_num2   = r_alu_num2;
        halted     = 1'b0;
        unique case (r_state)
            ST_FETCH: begin
                mem_req  = r_started;
                mem_addr = r_pc;
            end
            ST_EXECUTE: begin
                if (w_is_alu) begin
                    alu_opcode = w_op;
                    alu_num1   = r_a;
                    alu_num2   = r_b;
                end
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (w_op == OP_STORE);
                mem_addr  = r_a[ADDR_W-1:0];
                mem_wdata = r_b;
            end
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers; the last ALU operands are kept so the ALU inputs hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_alu_num1 <= '0;
            r_alu_num2 <= '0;
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (w_mem_done) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                ST_DECODE: begin
                    r_a <= w_rf_rdata_a;
                    r_b <= w_rf_rdata_b;
                end
                ST_EXECUTE: begin
                    if (w_is_alu) begin
                        r_res      <= alu_result;
                        r_alu_num1 <= r_a;
                        r_alu_num2 <= r_b;
                    end else if (w_op == OP_LDI) begin
                        r_res <= {8'h00, w_imm};
                    end else if (w_op == OP_JMP) begin
                        r_pc <= ADDR_W'(w_imm);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
